// File: rtl/countdown_display_pkg.sv
// Shared types, glyph constants and BCD decoding for the countdown display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package countdown_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_LOW     = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        GL_BLANK = 2'd0,
        GL_DASH  = 2'd1,
        GL_A     = 2'd2,
        GL_DIGIT = 2'd3
    } glyph_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_E     = 7'h06;

    // Non-BCD codes 10..15 render as 'E'
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/countdown_display_seg7_encode.sv
// Combinational glyph selector: turns a glyph choice plus BCD digit into
// active-low segment drive.
module seg7_encode
    import countdown_display_pkg::*;
(
    input  glyph_e     sel_i,
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (sel_i)
            GL_BLANK: seg_o = SEG_BLANK;
            GL_DASH:  seg_o = SEG_DASH;
            GL_A:     seg_o = SEG_A;
            GL_DIGIT: seg_o = bcd_to_seg(bcd_i);
            default:  seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_display.sv
// Four-digit multiplexed seven-segment driver for the countdown stage:
// blanking, armed glyph, final-seconds blink and latched expiry flash.
module countdown_display
    import countdown_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] value_three,
    input  logic [3:0] value_two,
    input  logic [3:0] value_one,
    input  logic       sec_timer,
    input  logic       clear,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       expired
);

    localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

    state_e        state_q, state_d;
    logic          phase_q, phase_d;
    logic [3:0]    d3_q, d2_q, d1_q;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    slot_q, slot_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          expired_q, expired_d;
    glyph_e        glyph_sel;
    logic [3:0]    glyph_bcd;
    logic          zero_all;

    assign zero_all = (value_three == 4'd0) && (value_two == 4'd0) && (value_one == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (!zero_all) state_d = ST_RUN;
            ST_RUN: begin
                if (zero_all)
                    state_d = ST_IDLE;
                else if ((value_three == 4'd0) && (value_two == 4'd0))
                    state_d = ST_LOW;
            end
            ST_LOW: begin
                if (zero_all)
                    state_d = ST_EXPIRED;
                else if ((value_three != 4'd0) || (value_two != 4'd0))
                    state_d = ST_RUN;
            end
            ST_EXPIRED: if (clear) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // A state change always restarts the blink on its visible half
        phase_d = phase_q;
        if (state_d != state_q)
            phase_d = 1'b0;
        else if (sec_timer && ((state_q == ST_LOW) || (state_q == ST_EXPIRED)))
            phase_d = ~phase_q;
    end

    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        slot_d = (div_q == DIV_LAST) ? slot_q + 2'd1 : slot_q;
    end

    // Output selection looks ahead to the slot being registered so an/seg line up
    always_comb begin
        glyph_sel = GL_BLANK;
        glyph_bcd = d1_q;
        if (state_q == ST_EXPIRED) begin
            glyph_sel = phase_q ? GL_BLANK : GL_DASH;
        end else if ((state_q == ST_RUN) || ((state_q == ST_LOW) && !phase_q)) begin
            case (slot_d)
                2'd3: glyph_sel = GL_A;
                2'd2: begin
                    glyph_bcd = d3_q;
                    glyph_sel = (d3_q == 4'd0) ? GL_BLANK : GL_DIGIT;
                end
                2'd1: begin
                    glyph_bcd = d2_q;
                    glyph_sel = ((d3_q == 4'd0) && (d2_q == 4'd0)) ? GL_BLANK : GL_DIGIT;
                end
                default: begin
                    glyph_bcd = d1_q;
                    glyph_sel = GL_DIGIT;
                end
            endcase
        end
        an_d      = (div_d == '0) ? 4'hF : ~(4'b0001 << slot_d);
        expired_d = (state_q == ST_EXPIRED);
    end

    seg7_encode u_encode (
        .sel_i (glyph_sel),
        .bcd_i (glyph_bcd),
        .seg_o (seg_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d3_q      <= 4'd0;
            d2_q      <= 4'd0;
            d1_q      <= 4'd0;
            div_q     <= '0;
            slot_q    <= 2'd0;
            seg_q     <= SEG_BLANK;
            an_q      <= 4'hF;
            expired_q <= 1'b0;
        end else begin
            d3_q      <= value_three;
            d2_q      <= value_two;
            d1_q      <= value_one;
            div_q     <= div_d;
            slot_q    <= slot_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            expired_q <= expired_d;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign expired = expired_q;

endmodule
